// File: rtl/sb_arbiter.sv
// sb_arbiter: round-robin arbiter for the shared SB bus.
// Supports bus lock, parks the bus on master 0, and masks split masters
// until the slave signals resume.
// Optional: define SB_ARB_TIMEOUT_EN to force an unlocked owner off the bus
// after MAX_TENURE cycles of tenure when another master is waiting.
module sb_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int SEL_WIDTH   = 2,
  parameter int MAX_TENURE  = 16
) (
  input  logic                   sb_clk,
  input  logic                   sb_resetn,
  input  logic [NUM_MASTERS-1:0] sb_busreq,
  input  logic [NUM_MASTERS-1:0] sb_lock,
  input  logic [1:0]             sb_trans,
  input  logic                   sb_ready,
  input  logic [1:0]             sb_resp,
  input  logic [NUM_MASTERS-1:0] sb_split_resume,
  output logic [NUM_MASTERS-1:0] sb_grant,
  output logic [SEL_WIDTH-1:0]   sb_master_sel,
  output logic                   sb_mastlock,
  output logic [NUM_MASTERS-1:0] sb_split_mask
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  // Reject configurations the select bus cannot encode.
  if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || (2**SEL_WIDTH) < NUM_MASTERS || MAX_TENURE < 1) begin : g_bad_params
    $error("sb_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_PARK, S_OWN, S_SPLIT} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_d, mask_d;
  logic [SEL_WIDTH-1:0]   sel_d, ptr_q, ptr_d, winner;
  logic                   mastlock_d, new_grant, go_park, preempt;

  logic [NUM_MASTERS-1:0] eligible, others, owner_bit;
  logic                   split_hit, releasable, release_pt;

  assign eligible   = sb_busreq & ~sb_split_mask;
  assign owner_bit  = NUM_MASTERS'(1) << sb_master_sel;
  assign others     = eligible & ~owner_bit;
  assign split_hit  = (sb_resp == 2'd3) && !sb_ready;
  // IDLE and NONSEQ are the only trans types that mark a burst boundary.
  assign releasable = sb_ready && !sb_lock[sb_master_sel] && !sb_trans[0];
  assign release_pt = releasable && !sb_busreq[sb_master_sel];

  // First requester found searching upward from (from+1), wrapping around.
  function automatic logic [SEL_WIDTH-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                                   input logic [SEL_WIDTH-1:0]   from);
    logic [SEL_WIDTH-1:0] pick;
    logic                 found;
    int                   idx;
    pick  = from;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = (int'(from) + k) % NUM_MASTERS;
      if (!found && req[idx[IW-1:0]]) begin
        pick  = SEL_WIDTH'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef SB_ARB_TIMEOUT_EN
  localparam int             TW      = $clog2(MAX_TENURE) + 1;
  localparam logic [TW-1:0]  TEN_MAX = TW'(MAX_TENURE);
  logic [TW-1:0] tenure_q;

  // Tenure counter: restarts on every new grant and saturates at the limit.
  always_ff @(posedge sb_clk or negedge sb_resetn) begin
    if (!sb_resetn) begin
      tenure_q <= '0;
    end else if (new_grant) begin
      tenure_q <= '0;
    end else if (state_q == S_OWN && tenure_q != TEN_MAX) begin
      tenure_q <= tenure_q + TW'(1);
    end
  end

  assign preempt = (tenure_q == TEN_MAX) && releasable;
`else
  assign preempt = 1'b0;
`endif

  // Next-state and registered-output decisions for the arbitration FSM.
  always_comb begin
    state_d    = state_q;
    grant_d    = sb_grant;
    sel_d      = sb_master_sel;
    ptr_d      = ptr_q;
    mastlock_d = 1'b0;
    mask_d     = sb_split_mask & ~sb_split_resume;
    new_grant  = 1'b0;
    go_park    = 1'b0;
    winner     = '0;
    case (state_q)
      S_PARK: begin
        if (eligible != '0) begin
          new_grant = 1'b1;
          winner    = rr_pick(eligible, ptr_q);
        end else begin
          go_park = 1'b1;
        end
      end
      S_OWN: begin
        mastlock_d = sb_lock[sb_master_sel];
        if (split_hit) begin
          mask_d     = mask_d | owner_bit;
          grant_d    = '0;
          mastlock_d = 1'b0;
          state_d    = S_SPLIT;
        end else if ((release_pt || preempt) && others != '0) begin
          new_grant = 1'b1;
          winner    = rr_pick(others, sb_master_sel);
        end else if (release_pt) begin
          go_park = 1'b1;
        end
      end
      S_SPLIT: begin
        if (eligible != '0) begin
          new_grant = 1'b1;
          winner    = rr_pick(eligible, ptr_q);
        end else begin
          go_park = 1'b1;
        end
      end
      default: go_park = 1'b1;
    endcase
    if (new_grant) begin
      state_d = S_OWN;
      grant_d = NUM_MASTERS'(1) << winner;
      sel_d   = winner;
      ptr_d   = winner;
    end
    if (go_park) begin
      state_d = S_PARK;
      grant_d = {{(NUM_MASTERS-1){1'b0}}, ~mask_d[0]};
      sel_d   = '0;
    end
  end

  // State and output registers; reset parks the bus on master 0.
  always_ff @(posedge sb_clk or negedge sb_resetn) begin
    if (!sb_resetn) begin
      state_q       <= S_PARK;
      sb_grant      <= NUM_MASTERS'(1);
      sb_master_sel <= '0;
      sb_mastlock   <= 1'b0;
      sb_split_mask <= '0;
      ptr_q         <= '0;
    end else begin
      state_q       <= state_d;
      sb_grant      <= grant_d;
      sb_master_sel <= sel_d;
      sb_mastlock   <= mastlock_d;
      sb_split_mask <= mask_d;
      ptr_q         <= ptr_d;
    end
  end

endmodule

// File: tb/tb_sb_arbiter.sv
// tb_sb_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic checked against a behavioural arbitration model.
module tb_sb_arbiter;

  localparam int N    = 3;
  localparam int SW   = 2;
  localparam int MAXT = 16;
`ifdef SB_ARB_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic          sb_clk = 1'b0;
  logic          sb_resetn = 1'b1;
  logic [N-1:0]  busreq, lock, resume;
  logic [1:0]    trans, resp;
  logic          ready;
  logic [N-1:0]  grant, mask;
  logic [SW-1:0] sel;
  logic          mastlock;

  int compared   = 0;
  int mismatched = 0;

  sb_arbiter #(.NUM_MASTERS(N), .SEL_WIDTH(SW), .MAX_TENURE(MAXT)) dut (
    .sb_clk          (sb_clk),
    .sb_resetn       (sb_resetn),
    .sb_busreq       (busreq),
    .sb_lock         (lock),
    .sb_trans        (trans),
    .sb_ready        (ready),
    .sb_resp         (resp),
    .sb_split_resume (resume),
    .sb_grant        (grant),
    .sb_master_sel   (sel),
    .sb_mastlock     (mastlock),
    .sb_split_mask   (mask)
  );

  // Free-running bus clock.
  always #5 sb_clk = ~sb_clk;

  typedef struct {
    logic [2:0] busreq;
    logic [2:0] lock;
    logic [1:0] trans;
    logic       ready;
    logic [1:0] resp;
    logic [2:0] resume;
    logic [2:0] e_grant;
    logic [1:0] e_sel;
    logic       e_lock;
    logic [2:0] e_mask;
  } vec_t;

  vec_t vecs[$];

  // Behavioural model: owner index (-1 when nobody owns), a one-cycle gap flag
  // after SPLIT, the last granted master and how long the owner has held on.
  int         m_owner, m_ptr, m_tenure, m_sel;
  bit         m_gap, m_lock;
  logic [2:0] m_grant, m_mask;

  function automatic vec_t mk(logic [2:0] b, logic [2:0] l, logic [1:0] t, logic r,
                              logic [1:0] rs, logic [2:0] res, logic [2:0] eg,
                              logic [1:0] es, logic el, logic [2:0] em);
    vec_t v;
    v.busreq = b; v.lock = l; v.trans = t; v.ready = r; v.resp = rs; v.resume = res;
    v.e_grant = eg; v.e_sel = es; v.e_lock = el; v.e_mask = em;
    return v;
  endfunction

  function automatic int pick(logic [2:0] req, int from);
    for (int k = 1; k <= N; k++) begin
      int idx;
      idx = (from + k) % N;
      if (((req >> idx) & 3'b001) != 3'b000) return idx;
    end
    return from;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_gap = 0; m_ptr = 0; m_tenure = 0;
    m_grant = 3'b001; m_sel = 0; m_lock = 0; m_mask = 3'b000;
  endtask

  task automatic model_grant(int w);
    m_owner = w; m_grant = 3'(1 << w); m_sel = w; m_ptr = w; m_tenure = 0;
  endtask

  task automatic model_park(logic [2:0] nmask);
    m_owner = -1; m_grant = {2'b00, ~nmask[0]}; m_sel = 0;
  endtask

  task automatic model_step();
    logic [2:0] elig, others, nmask;
    logic [1:0] oi;
    bit rel_ok, free_bus, pre;
    elig  = busreq & ~m_mask;
    nmask = m_mask & ~resume;
    if (m_gap) begin
      m_gap = 0; m_lock = 0;
      if (elig != 0) model_grant(pick(elig, m_ptr)); else model_park(nmask);
    end else if (m_owner < 0) begin
      m_lock = 0;
      if (elig != 0) model_grant(pick(elig, m_ptr)); else model_park(nmask);
    end else begin
      oi = 2'(m_owner);
      if (resp == 2'd3 && !ready) begin
        nmask[oi] = 1'b1; m_gap = 1; m_owner = -1; m_grant = 3'b000; m_lock = 0;
      end else begin
        m_lock   = lock[oi];
        rel_ok   = ready && !lock[oi] && (trans == 2'd0 || trans == 2'd2);
        free_bus = rel_ok && !busreq[oi];
        pre      = TMO && rel_ok && (m_tenure >= MAXT);
        others   = elig;
        others[oi] = 1'b0;
        if ((free_bus || pre) && others != 0) model_grant(pick(others, m_owner));
        else if (free_bus) model_park(nmask);
        else m_tenure++;
      end
    end
    m_mask = nmask;
  endtask

  task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [2:0] eg, input logic [1:0] es,
                             input logic el, input logic [2:0] em);
    cmp({name, ".grant"}, 8'(grant), 8'(eg));
    cmp({name, ".sel"}, 8'(sel), 8'(es));
    cmp({name, ".mastlock"}, 8'(mastlock), 8'(el));
    cmp({name, ".split_mask"}, 8'(mask), 8'(em));
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, m_grant, 2'(m_sel), m_lock, m_mask);
  endtask

  task automatic applyStimulus(input logic [2:0] b, input logic [2:0] l, input logic [1:0] t,
                               input logic r, input logic [1:0] rs, input logic [2:0] res);
    busreq = b; lock = l; trans = t; ready = r; resp = rs; resume = res;
  endtask

  // One clock edge for both DUT and model, then settle before sampling.
  task automatic tick();
    @(posedge sb_clk);
    model_step();
    #1;
  endtask

  task automatic doReset(input string name);
    applyStimulus(3'b000, 3'b000, 2'd0, 1'b1, 2'd1, 3'b000);
    sb_resetn = 1'b1;
    #1;
    sb_resetn = 1'b0;
    @(negedge sb_clk);
    checkOutput(name, 3'b001, 2'd0, 1'b0, 3'b000);
    @(negedge sb_clk);
    sb_resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int held;
    // Directed table: inputs held for one cycle, outputs expected after the edge.
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b110, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b010, 2'd1, 0, 3'b000));
    vecs.push_back(mk(3'b110, 3'b000, 2'd2, 1, 2'd1, 3'b000, 3'b010, 2'd1, 0, 3'b000));
    vecs.push_back(mk(3'b100, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b100, 2'd2, 0, 3'b000));
    vecs.push_back(mk(3'b100, 3'b100, 2'd2, 1, 2'd1, 3'b000, 3'b100, 2'd2, 1, 3'b000));
    vecs.push_back(mk(3'b001, 3'b100, 2'd0, 1, 2'd1, 3'b000, 3'b100, 2'd2, 1, 3'b000));
    vecs.push_back(mk(3'b001, 3'b100, 2'd0, 1, 2'd1, 3'b000, 3'b100, 2'd2, 1, 3'b000));
    vecs.push_back(mk(3'b001, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b011, 3'b000, 2'd2, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b010, 3'b000, 2'd3, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 0, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b010, 2'd1, 0, 3'b000));
    vecs.push_back(mk(3'b011, 3'b000, 2'd0, 0, 2'd3, 3'b000, 3'b000, 2'd1, 0, 3'b010));
    vecs.push_back(mk(3'b011, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b010));
    vecs.push_back(mk(3'b011, 3'b000, 2'd2, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b010));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b010));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b010));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1, 2'd1, 3'b010, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b010, 2'd1, 0, 3'b000));
    vecs.push_back(mk(3'b010, 3'b000, 2'd0, 0, 2'd3, 3'b010, 3'b000, 2'd1, 0, 3'b010));
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b010));
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1, 2'd1, 3'b010, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b001, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b001, 3'b000, 2'd0, 0, 2'd3, 3'b000, 3'b000, 2'd0, 0, 3'b001));
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b000, 2'd0, 0, 3'b001));
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b000, 2'd0, 0, 3'b001));
    vecs.push_back(mk(3'b001, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b000, 2'd0, 0, 3'b001));
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1, 2'd1, 3'b001, 3'b001, 2'd0, 0, 3'b000));
    vecs.push_back(mk(3'b100, 3'b000, 2'd0, 1, 2'd1, 3'b000, 3'b100, 2'd2, 0, 3'b000));
    vecs.push_back(mk(3'b100, 3'b000, 2'd2, 0, 2'd2, 3'b000, 3'b100, 2'd2, 0, 3'b000));
    vecs.push_back(mk(3'b000, 3'b000, 2'd0, 1, 2'd2, 3'b000, 3'b001, 2'd0, 0, 3'b000));

    doReset("reset");
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].busreq, vecs[i].lock, vecs[i].trans, vecs[i].ready,
                    vecs[i].resp, vecs[i].resume);
      tick();
      checkOutput($sformatf("vec%0d", i), vecs[i].e_grant, vecs[i].e_sel,
                  vecs[i].e_lock, vecs[i].e_mask);
    end

    // Asynchronous reset in the middle of a locked tenure.
    doReset("reset2");
    applyStimulus(3'b010, 3'b000, 2'd2, 1'b1, 2'd1, 3'b000);
    tick();
    applyStimulus(3'b010, 3'b010, 2'd2, 1'b1, 2'd1, 3'b000);
    tick();
    checkModel("locked_tenure");
    #2;
    sb_resetn = 1'b0;
    #1;
    checkOutput("async_reset", 3'b001, 2'd0, 1'b0, 3'b000);
    @(negedge sb_clk);
    sb_resetn = 1'b1;
    model_reset();

`ifdef SB_ARB_TIMEOUT_EN
    // Master 0 streams NONSEQ while master 2 waits: the tenure counter starts
    // at 0 on the grant edge, so master 0 sees its grant for MAXT+1 cycles.
    doReset("reset_tmo");
    applyStimulus(3'b001, 3'b000, 2'd2, 1'b1, 2'd1, 3'b000);
    tick();
    held = (grant == 3'b001) ? 1 : 0;
    applyStimulus(3'b101, 3'b000, 2'd2, 1'b1, 2'd1, 3'b000);
    for (int c = 0; c < 40 && grant == 3'b001; c++) begin
      tick();
      checkModel($sformatf("tmo%0d", c));
      if (grant == 3'b001) held++;
    end
    cmp("tenure_hold", 8'(held), 8'(MAXT + 1));
    cmp("tenure_winner", 8'(grant), 8'(3'b100));

    // A locked owner is never preempted, however long it holds the bus.
    doReset("reset_lock");
    applyStimulus(3'b001, 3'b001, 2'd2, 1'b1, 2'd1, 3'b000);
    tick();
    applyStimulus(3'b101, 3'b001, 2'd2, 1'b1, 2'd1, 3'b000);
    for (int c = 0; c < 40; c++) tick();
    checkModel("locked_long");
    cmp("locked_no_preempt", 8'(grant), 8'(3'b001));
`endif

    // Randomized traffic against the model.
    doReset("reset_rand");
    for (int c = 0; c < 1500; c++) begin
      int r;
      r = $urandom_range(0, 15);
      applyStimulus(3'($urandom),
                    ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000,
                    2'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) != 0),
                    (r == 0) ? 2'd3 : ((r == 1) ? 2'd2 : 2'd1),
                    ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000);
      tick();
      checkModel($sformatf("rand%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
